// File: rtl/grf_wport_sched.sv
// rtl/grf_wport_sched.sv - GRF write-port scheduler sharing one write port between WB and MDU results.
// Optional GRF_WPORT_TRACE_EN prints a GRF trace line per write; logic is unchanged.
module grf_wport_sched #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic [31:0] mdu_pc,
  output logic        pipe_stall,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic [31:0] busy_mask
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_DRAIN} state_t;

  state_t         state, state_nxt;
  logic [4:0]     q_addr [FIFO_DEPTH];
  logic [31:0]    q_data [FIFO_DEPTH];
  logic [31:0]    q_pc   [FIFO_DEPTH];
  logic [AW-1:0]  head, tail;
  logic [CW-1:0]  count, count_nxt;
  logic [SW-1:0]  starve, starve_nxt;

  logic        full, empty, wb_req, mdu_fire, mdu_live;
  logic        pop, push, bypass;
  logic        sel_we;
  logic [4:0]  sel_a3;
  logic [31:0] sel_wd, sel_pc;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign mdu_ready = !full;
  assign wb_req    = wb_we && (wb_addr != 5'd0);
  assign mdu_fire  = mdu_valid && mdu_ready;
  assign mdu_live  = mdu_fire && (mdu_addr != 5'd0);
  assign pipe_stall = (state == S_DRAIN);

  // Write-port arbitration: forced drain, then WB, then buffered head, then MDU bypass.
  always_comb begin
    pop    = 1'b0;
    bypass = 1'b0;
    sel_we = 1'b0;
    sel_a3 = '0;
    sel_wd = '0;
    sel_pc = '0;
    if (state == S_DRAIN) begin
      pop = !empty;
    end else if (wb_req) begin
      sel_we = 1'b1;
      sel_a3 = wb_addr;
      sel_wd = wb_data;
      sel_pc = wb_pc;
    end else if (!empty) begin
      pop = 1'b1;
    end else if (mdu_live) begin
      bypass = 1'b1;
      sel_we = 1'b1;
      sel_a3 = mdu_addr;
      sel_wd = mdu_data;
      sel_pc = mdu_pc;
    end
    if (pop) begin
      sel_we = 1'b1;
      sel_a3 = q_addr[head];
      sel_wd = q_data[head];
      sel_pc = q_pc[head];
    end
  end

  assign push = mdu_live && !bypass;

  assign grf_we = sel_we && !reset;
  assign grf_a3 = grf_we ? sel_a3 : 5'd0;
  assign grf_wd = grf_we ? sel_wd : 32'd0;
  assign grf_pc = grf_we ? sel_pc : 32'd0;

  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    starve_nxt = starve;
    if (empty || pop)
      starve_nxt = '0;
    else if (starve != SW'(STARVE_LIMIT))
      starve_nxt = starve + SW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count_nxt != '0) state_nxt = S_PEND;
      S_PEND: begin
        if (count_nxt == '0)
          state_nxt = S_IDLE;
        else if (starve_nxt == SW'(STARVE_LIMIT))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: if (count_nxt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ({1'b0, AW'(AW'(i) - head)} < count)
        busy_mask = busy_mask | (32'd1 << q_addr[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      starve <= starve_nxt;
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_addr[tail] <= mdu_addr;
      q_data[tail] <= mdu_data;
      q_pc[tail]   <= mdu_pc;
    end
  end

`ifdef GRF_WPORT_TRACE_EN
  always_ff @(posedge clk) begin
    if (grf_we)
      $display("%0d@%h: $%0d <= %h", $time, grf_pc, grf_a3, grf_wd);
  end
`endif

endmodule

// File: tb/tb_grf_wport_sched.sv
// tb/tb_grf_wport_sched.sv - scoreboard bench for grf_wport_sched with a queue-level reference model.
module tb_grf_wport_sched;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b1;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, wb_pc;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data, mdu_pc;
  logic        pipe_stall, grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc, busy_mask;

  always #5 clk = ~clk;

  grf_wport_sched #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr),
    .mdu_data(mdu_data), .mdu_pc(mdu_pc),
    .pipe_stall(pipe_stall), .grf_we(grf_we), .grf_a3(grf_a3),
    .grf_wd(grf_wd), .grf_pc(grf_pc), .busy_mask(busy_mask)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; logic [31:0] pc; } ent_t;
  typedef struct { bit rst; bit we; bit rdy; bit stall; logic [31:0] busy; } st_t;

  ent_t mq[$];
  ent_t exp_wr[$];
  st_t  exp_st[$];
  int   starve;
  bit   drain;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, predict its outcome from the queue model, then advance past the edge.
  task automatic step(input bit rst, input bit wbwe, input logic [4:0] wa, input logic [31:0] wd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md, output bit fired);
    st_t  s;
    ent_t e;
    int   size;
    bit   pop, byp, live;
    reset = rst; wb_we = wbwe; wb_addr = wa; wb_data = wd; wb_pc = $urandom;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md; mdu_pc = {md[15:0], md[31:16]} ^ 32'h0040_0000;
    fired = 0;
    s = '{rst: rst, we: 0, rdy: 0, stall: 0, busy: 0};
    if (rst) begin
      mq.delete(); starve = 0; drain = 0;
    end else begin
      size = mq.size();
      s.rdy = size < DEPTH;
      s.stall = drain;
      foreach (mq[i]) s.busy |= 32'd1 << mq[i].a;
      fired = mv && s.rdy;
      live = fired && ma != 0;
      pop = 0; byp = 0;
      if (drain) pop = size > 0;
      else if (wbwe && wa != 0) begin
        s.we = 1; e = '{a: wa, d: wd, pc: wb_pc}; exp_wr.push_back(e);
      end else if (size > 0) pop = 1;
      else if (live) begin
        byp = 1; s.we = 1; e = '{a: ma, d: md, pc: mdu_pc}; exp_wr.push_back(e);
      end
      if (pop) begin s.we = 1; exp_wr.push_back(mq.pop_front()); end
      if (live && !byp) begin e = '{a: ma, d: md, pc: mdu_pc}; mq.push_back(e); end
      starve = (size == 0 || pop) ? 0 : (starve < LIMIT ? starve + 1 : LIMIT);
      if (mq.size() == 0) drain = 0;
      else if (starve == LIMIT) drain = 1;
    end
    exp_st.push_back(s);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every cycle's status and pops the write scoreboard on each GRF write.
  always @(negedge clk) begin
    st_t  s;
    ent_t e;
    if (exp_st.size() > 0) begin
      s = exp_st.pop_front();
      if (s.rst) begin
        check("grf_in_reset", {grf_we, grf_a3, grf_wd, grf_pc}, 0);
      end else begin
        check("grf_we", grf_we, s.we);
        check("mdu_ready", mdu_ready, s.rdy);
        check("pipe_stall", pipe_stall, s.stall);
        check("busy_mask", busy_mask, s.busy);
        if (grf_we) begin
          if (exp_wr.size() == 0) check("unexpected_write", {grf_a3, grf_wd}, 0);
          else begin
            e = exp_wr.pop_front();
            check("grf_write", {grf_a3, grf_wd, grf_pc}, {e.a, e.d, e.pc});
          end
        end else begin
          check("grf_idle_zero", {grf_a3, grf_wd, grf_pc}, 0);
        end
      end
    end
  end

  bit   f;
  bit   pend;
  logic [4:0]  pa;
  logic [31:0] pd;

  initial begin
    starve = 0; drain = 0;
    step(1, 0, 0, 0, 0, 0, 0, f);
    step(1, 0, 0, 0, 0, 0, 0, f);
    check("reset_ready", mdu_ready, 1);
    check("reset_stall", pipe_stall, 0);
    check("reset_busy", busy_mask, 0);
    step(0, 0, 0, 0, 0, 0, 0, f);

    // bypass
    step(0, 0, 0, 0, 1, 5'd5, 32'h1234, f);
    check("bypass_busy", busy_mask, 0);

    // WB vs MDU conflict
    step(0, 1, 5'd3, 32'hAAAA_0003, 1, 5'd7, 32'h7777, f);
    check("conflict_busy", busy_mask, 32'h80);
    step(0, 0, 0, 0, 0, 0, 0, f);
    check("conflict_busy_clear", busy_mask, 0);

    // fill under continuous WB, then a held fifth result
    for (int i = 0; i < DEPTH; i++) step(0, 1, 5'd2, 32'hB0 + i, 1, 5'(10 + i), 32'hC0 + i, f);
    check("fill_ready", mdu_ready, 0);
    step(0, 1, 5'd2, 32'hB9, 1, 5'd20, 32'hD0, f);
    check("fill_held", f, 0);
    step(0, 0, 0, 0, 1, 5'd20, 32'hD0, f);
    check("fill_held_pop_cycle", f, 0);
    step(0, 0, 0, 0, 1, 5'd20, 32'hD0, f);
    check("fill_accept", f, 1);
    while (mq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, f);

    // starvation
    step(0, 1, 5'd4, 32'hE0, 1, 5'd9, 32'h9999, f);
    for (int i = 0; i < LIMIT; i++) step(0, 1, 5'd4, 32'hE1 + i, 0, 0, 0, f);
    check("starve_stall", pipe_stall, 1);
    step(0, 1, 5'd4, 32'hEF, 0, 0, 0, f);
    check("starve_done", pipe_stall, 0);
    check("starve_busy", busy_mask, 0);

    // address-0 MDU result
    step(0, 0, 0, 0, 1, 5'd0, 32'hDEAD, f);
    check("addr0_fire", f, 1);
    check("addr0_busy", busy_mask, 0);

    // reset during drain
    for (int i = 0; i < 3; i++) step(0, 1, 5'd6, 32'hF0 + i, 1, 5'(21 + i), 32'h50 + i, f);
    for (int i = 0; i < LIMIT; i++) step(0, 1, 5'd6, 32'hF8, 0, 0, 0, f);
    check("drain_stall", pipe_stall, 1);
    step(1, 0, 0, 0, 0, 0, 0, f);
    check("flush_stall", pipe_stall, 0);
    check("flush_busy", busy_mask, 0);
    check("flush_ready", mdu_ready, 1);

    // randomized traffic; MDU holds a result until it is accepted
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1; pa = 5'($urandom); pd = $urandom;
      end
      if ($urandom_range(0, 299) == 0) begin
        step(1, 0, 0, 0, 0, 0, 0, f);
      end else begin
        step(0, $urandom_range(0, 9) < 6, 5'($urandom), $urandom, pend, pa, pd, f);
        if (f) pend = 0;
      end
    end
    while (mq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, f);
    step(0, 0, 0, 0, 0, 0, 0, f);
    check("scoreboard_empty", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_wport_sched.md
# grf_wport_sched

Write-port scheduler for the general register file in the 5-stage MIPS32 pipeline. It shares the single GRF write port between the WB stage and the long-latency multiply/divide unit (MDU) result port. Late MDU results are buffered in a small FIFO, and a per-register busy mask is exported to hazard control. If MDU results wait too long, the scheduler forces a drain by stalling the pipeline.

## Interface
- FIFO_DEPTH, 4, MDU result buffer entries; power of two, at least 2
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before a forced drain; at least 1
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- wb_we  in  1  WB stage write request
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_pc  in  32  PC of the WB instruction
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  scheduler accepts the MDU result this cycle
- mdu_addr  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_pc  in  32  PC of the MDU instruction
- pipe_stall  out  1  freeze the pipeline, WB stage included
- grf_we  out  1  GRF write enable
- grf_a3  out  5  GRF write address
- grf_wd  out  32  GRF write data
- grf_pc  out  32  PC of the instruction being written
- busy_mask  out  32  bit r = 1 while any FIFO entry targets register r

## Operation
- Definitions:
  - wb_req = wb_we && wb_addr != 0
  - mdu_fire = mdu_valid && mdu_ready
  - Writes to $0 never reach the GRF.
- MDU results with address 0 complete the handshake and are discarded; they are neither enqueued nor written.
- States:
  - IDLE: FIFO empty.
  - PEND: FIFO non-empty.
  - DRAIN: forced drain in progress.
- Write-port selection, priority per cycle:
  - DRAIN: pop the FIFO head. WB is ignored; it holds under pipe_stall.
  - else if wb_req: write WB.
  - else if FIFO non-empty: pop the head.
  - else if mdu_fire with a non-zero address: bypass, writing the MDU result directly without enqueuing.
- An MDU result that fires but is not bypassed is enqueued at the tail.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- mdu_ready = !full, using the registered count. It is not pop-aware.
- The FIFO preserves order. busy_mask is the OR of one-hot decodes of all valid entries.
- Hazard control stalls any instruction whose source or destination has a busy_mask bit set. This guarantees no WB write overtakes an older buffered write to the same register.
- Starvation counter:
  - Clears when the FIFO is empty or the head is popped.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - On reaching STARVE_LIMIT in PEND, the next state is DRAIN.
- In DRAIN:
  - pipe_stall = 1, and the head pops every cycle.
  - MDU pushes are still accepted while not full.
  - Return to IDLE in the cycle after the last entry pops, unless a push refills the FIFO; in that case stay in DRAIN.
- grf_* outputs are combinational from the selected source. grf_a3, grf_wd and grf_pc are 0 when grf_we = 0.

## Timing
- Reset values:
  - FIFO empty, state IDLE, counter 0.
  - mdu_ready = 1, pipe_stall = 0, busy_mask = 0.
  - grf_we = 0, and all grf_* outputs are 0 while reset is high.
- Latency:
  - WB write and MDU bypass: same cycle, 0 latency.
  - An enqueued entry is poppable from the next cycle.
  - busy_mask updates in the cycle after a push or pop.
- Forced drain: with a continuous WB stream, the head waits exactly STARVE_LIMIT cycles. pipe_stall rises in the following cycle, and that cycle pops the head.
- Full FIFO: mdu_ready = 0. The MDU must hold its result until mdu_ready returns.
- A reset asserted mid-operation, including mid-drain, flushes all buffered entries; they are lost. All outputs return to their reset values on the next edge.

## Configuration
- GRF_WPORT_TRACE_EN defined: every cycle with grf_we = 1 prints one $display line in the form "time@pc: $reg <= data" (decimal time, hex pc, decimal reg, hex data). This matches the GRF trace format used for comparison against the reference simulator.
- GRF_WPORT_TRACE_EN not defined: no simulation output. Logic is identical either way.

## Test plan
- Reset, then idle: mdu_ready = 1, grf_we = 0, busy_mask = 0, pipe_stall = 0.
- MDU bypass: FIFO empty, no WB, MDU result (addr 5, 0x1234) -> same cycle grf_we = 1, grf_a3 = 5, grf_wd = 0x00001234; busy_mask stays 0.
- Conflict: wb_req (addr 3) and MDU (addr 7) in the same cycle -> WB written; next cycle busy_mask = 0x80; it pops once WB is idle, then busy_mask returns to 0.
- Fill: 4 MDU results during continuous WB -> mdu_ready = 0 after the fourth; a fifth held result is accepted only after a pop.
- Starvation, STARVE_LIMIT = 8: one buffered entry plus continuous WB for 8 cycles -> pipe_stall = 1 next cycle, head written, back to IDLE the following cycle.
- Address-0 MDU result -> handshake completes, no grf_we, busy_mask unchanged; reset during DRAIN -> FIFO flushed, pipe_stall = 0.
